// File: rtl/sev_seg_pkg.sv
// Shared types and active-low {g..a} segment codes for the seven-segment snooper.
package sev_seg_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_HEX_0 = 7'h40;
  localparam seg_t SEG_HEX_1 = 7'h79;
  localparam seg_t SEG_HEX_2 = 7'h24;
  localparam seg_t SEG_HEX_3 = 7'h30;
  localparam seg_t SEG_HEX_4 = 7'h19;
  localparam seg_t SEG_HEX_5 = 7'h12;
  localparam seg_t SEG_HEX_6 = 7'h02;
  localparam seg_t SEG_HEX_7 = 7'h78;
  localparam seg_t SEG_HEX_8 = 7'h00;
  localparam seg_t SEG_HEX_9 = 7'h10;
  localparam seg_t SEG_HEX_A = 7'h08;
  localparam seg_t SEG_HEX_B = 7'h03;
  localparam seg_t SEG_HEX_C = 7'h46;
  localparam seg_t SEG_HEX_D = 7'h21;
  localparam seg_t SEG_HEX_E = 7'h06;
  localparam seg_t SEG_HEX_F = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic   legal;
    logic   is_blank;
    digit_t value;
  } pat_t;

endpackage

// File: rtl/sev_seg_pattern_decode.sv
// Combinational segment-pattern classifier; legal is set only for the 16 hex glyphs,
// is_blank only for the all-off pattern.
module sev_seg_pattern_decode
  import sev_seg_pkg::*;
(
  input  seg_t seg,
  output pat_t pat
);

  always_comb begin
    pat = '{legal: 1'b1, is_blank: 1'b0, value: 4'h0};
    case (seg)
      SEG_HEX_0: pat.value = 4'h0;
      SEG_HEX_1: pat.value = 4'h1;
      SEG_HEX_2: pat.value = 4'h2;
      SEG_HEX_3: pat.value = 4'h3;
      SEG_HEX_4: pat.value = 4'h4;
      SEG_HEX_5: pat.value = 4'h5;
      SEG_HEX_6: pat.value = 4'h6;
      SEG_HEX_7: pat.value = 4'h7;
      SEG_HEX_8: pat.value = 4'h8;
      SEG_HEX_9: pat.value = 4'h9;
      SEG_HEX_A: pat.value = 4'hA;
      SEG_HEX_B: pat.value = 4'hB;
      SEG_HEX_C: pat.value = 4'hC;
      SEG_HEX_D: pat.value = 4'hD;
      SEG_HEX_E: pat.value = 4'hE;
      SEG_HEX_F: pat.value = 4'hF;
      SEG_BLANK: begin
        pat.legal    = 1'b0;
        pat.is_blank = 1'b1;
      end
      default:   pat.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sev_seg_decoder.sv
// Recovers per-digit hex values by snooping a multiplexed seven-segment bus.
// Define SEV_SEG_DECODER_ERR_EN to build the err pulse and saturating err_count.
module sev_seg_decoder
  import sev_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
)
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       Seg,
  input  logic [7:0]       AN,
  output digit_t [7:0]     digits,
  output logic [7:0]       digit_valid,
  output logic [7:0]       blank,
  output logic             cap_strobe,
  output logic [2:0]       cap_idx,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam logic [15:0] SETTLE = 16'(SETTLE_CYCLES);

  logic [7:0]  an_p0;
  seg_t        seg_p0;
  logic [15:0] cnt_p0;
  logic        primed_p0;
  logic        armed_p0;
  logic        same;
  logic        fire;
  logic        one_hot;
  logic        cap_ok;
  logic [2:0]  idx;
  pat_t        pat;

  function automatic logic [2:0] low_idx(input logic [7:0] an);
    logic [2:0] i;
    i = 3'd0;
    for (int b = 0; b < 8; b++)
      if (!an[b]) i = 3'(b);
    return i;
  endfunction

  sev_seg_pattern_decode u_decode (
    .seg (seg_p0),
    .pat (pat)
  );

  // primed_p0 keeps a post-reset sample from matching the cleared registers
  assign same    = primed_p0 && (AN == an_p0) && (Seg == seg_p0);
  assign fire    = armed_p0 && (cnt_p0 == SETTLE);
  assign one_hot = $onehot(~an_p0);
  assign idx     = low_idx(an_p0);
  assign cap_ok  = fire && one_hot && (pat.legal || pat.is_blank);

  // Stage p0: sample register and dwell counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_p0     <= 8'h00;
      seg_p0    <= 7'h00;
      cnt_p0    <= 16'd0;
      primed_p0 <= 1'b0;
      armed_p0  <= 1'b0;
    end else begin
      an_p0     <= AN;
      seg_p0    <= Seg;
      primed_p0 <= 1'b1;
      if (!same) begin
        cnt_p0   <= 16'd1;
        armed_p0 <= 1'b1;
      end else begin
        if (cnt_p0 != SETTLE) cnt_p0 <= cnt_p0 + 16'd1;
        if (fire) armed_p0 <= 1'b0;
      end
    end
  end

  // Stage p1: capture outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits      <= '0;
      digit_valid <= 8'h00;
      blank       <= 8'h00;
      cap_strobe  <= 1'b0;
      cap_idx     <= 3'd0;
    end else begin
      cap_strobe <= cap_ok;
      if (cap_ok) begin
        cap_idx          <= idx;
        digit_valid[idx] <= 1'b1;
        blank[idx]       <= pat.is_blank;
        if (!pat.is_blank) digits[idx] <= pat.value;
      end
    end
  end

`ifdef SEV_SEG_DECODER_ERR_EN
  logic idle;
  logic err_evt;

  assign idle    = (an_p0 == 8'hFF);
  assign err_evt = fire && !idle && !(one_hot && (pat.legal || pat.is_blank));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      err <= err_evt;
      if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
`else
  assign err       = 1'b0;
  assign err_count = 8'h00;
`endif

endmodule
